// File: rtl/tone_period_meter_if.sv
// tone_period_meter_if: result handshake bundle between the period meter and its consumer
//   period      inclk cycles between two consecutive rising edges
//   div_est     divider setting that would produce the measured period
//   meas_valid  result held until meas_ack
//   meas_ack    consumer accepts the current result
//   overrun     sticky: a result was dropped while meas_valid was high
//   timeout     sticky: no rising edge seen within the timeout window
interface tone_period_meter_if #(parameter int CNT_W = 32);
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] div_est;
   logic             meas_valid;
   logic             meas_ack;
   logic             overrun;
   logic             timeout;
   modport master (output period, div_est, meas_valid, overrun, timeout, input meas_ack);
   modport slave (input period, div_est, meas_valid, overrun, timeout, output meas_ack);
endinterface

// File: rtl/tone_period_meter.sv
// tone_period_meter: measures a square wave's period in inclk cycles and recovers its divider setting
//   inclk   clock
//   reset   synchronous, active-high
//   enable  1 = measure, 0 = idle and clear status (period/div_est held)
//   sig_in  asynchronous square wave under test
//   res     result handshake (period, div_est, meas_valid/meas_ack, overrun, timeout)
module tone_period_meter #(
   parameter int CNT_W       = 32,
   parameter int TIMEOUT     = 50_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic inclk,
   input  logic reset,
   input  logic enable,
   input  logic sig_in,
   tone_period_meter_if.master res
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ARM  = 2'd1;
   localparam logic [1:0] MEAS = 2'd2;
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [1:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic [CNT_W-1:0]       div_est_q, div_est_d;
   logic                   valid_q, valid_d;
   logic                   overrun_q, overrun_d;
   logic                   timeout_q, timeout_d;
   logic                   rise;
   logic [CNT_W-1:0]       p;

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
   // the edge that ends a measurement counts as its last cycle
   assign p = cnt_q + ONE;

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_d    = sync_q[SYNC_STAGES-1];
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      div_est_d = div_est_q;
      valid_d   = valid_q & ~res.meas_ack;
      overrun_d = overrun_q;
      timeout_d = timeout_q;
      if (!enable) begin
         state_d   = IDLE;
         cnt_d     = '0;
         valid_d   = 1'b0;
         overrun_d = 1'b0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: state_d = ARM;
            ARM: begin
               cnt_d   = rise ? '0 : cnt_q;
               state_d = rise ? MEAS : ARM;
            end
            MEAS: begin
               if (rise) begin
                  cnt_d = '0;
                  // an unacknowledged result is kept; the new one is dropped
                  if (valid_q && !res.meas_ack) begin
                     overrun_d = 1'b1;
                  end else begin
                     period_d  = p;
                     div_est_d = (p >> 1) - ONE;
                     valid_d   = 1'b1;
                  end
               end else if (cnt_q == TO_MAX) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = ARM;
               end else begin
                  cnt_d = p;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge inclk) begin
      if (reset) begin
         sync_q    <= '0;
         prev_q    <= 1'b0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         div_est_q <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         prev_q    <= prev_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         div_est_q <= div_est_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
      end
   end

   assign res.period     = period_q;
   assign res.div_est    = div_est_q;
   assign res.meas_valid = valid_q;
   assign res.overrun    = overrun_q;
   assign res.timeout    = timeout_q;
endmodule

// File: tb/tb_tone_period_meter.sv
// tb_tone_period_meter: directed self-checking bench for tone_period_meter
module tb_tone_period_meter;
   logic inclk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic sig_in;
   logic gen_on = 1'b0, gen_sig = 1'b0, man_sig = 1'b0;
   logic auto_ack = 1'b0, man_ack = 1'b0;
   int   hi = 5, lo = 5;
   int   cyc = 0, t_prev = 0, t_last = 0;
   logic mv_prev = 1'b0;
   int   checks = 0, errors = 0;

   tone_period_meter_if #(.CNT_W(32)) m ();

   tone_period_meter #(.CNT_W(32), .TIMEOUT(100), .SYNC_STAGES(2)) dut (
      .inclk  (inclk),
      .reset  (reset),
      .enable (enable),
      .sig_in (sig_in),
      .res    (m)
   );

   always #5 inclk = ~inclk;
   always @(posedge inclk) cyc <= cyc + 1;

   assign sig_in    = gen_on ? gen_sig : man_sig;
   assign m.meas_ack = auto_ack ? m.meas_valid : man_ack;

   task automatic tick();
      @(posedge inclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   initial forever begin
      if (gen_on) begin
         gen_sig = 1'b1;
         repeat (hi) tick();
         gen_sig = 1'b0;
         repeat (lo) tick();
      end else tick();
   end

   // timestamps of meas_valid rising edges, for pulse spacing
   always begin
      @(posedge inclk);
      #2;
      if (m.meas_valid && !mv_prev) begin
         t_prev = t_last;
         t_last = cyc;
      end
      mv_prev = m.meas_valid;
   end

   initial begin
      int w;
      repeat (3) tick();
      check("rst_period", m.period, 0);
      check("rst_div", m.div_est, 0);
      check("rst_valid", m.meas_valid, 0);
      check("rst_overrun", m.overrun, 0);
      check("rst_timeout", m.timeout, 0);
      reset = 1'b0;
      // divider setting 4: toggle every 5 cycles
      hi = 5; lo = 5; gen_on = 1'b1; auto_ack = 1'b1; enable = 1'b1;
      repeat (60) tick();
      check("t1_period", m.period, 10);
      check("t1_div", m.div_est, 4);
      check("t1_spacing", t_last - t_prev, 10);
      check("t1_overrun", m.overrun, 0);
      check("t1_timeout", m.timeout, 0);
      // fastest input
      enable = 1'b0; tick();
      hi = 1; lo = 1; enable = 1'b1;
      repeat (40) tick();
      check("t2_period", m.period, 2);
      check("t2_div", m.div_est, 0);
      check("t2_spacing", t_last - t_prev, 2);
      check("t2_overrun", m.overrun, 0);
      // odd period truncates
      enable = 1'b0; tick();
      hi = 5; lo = 6; enable = 1'b1;
      repeat (60) tick();
      check("t3_period", m.period, 11);
      check("t3_div", m.div_est, 4);
      check("t3_spacing", t_last - t_prev, 11);
      // no ack: first result (P=11) kept, later P=10 results dropped
      enable = 1'b0; auto_ack = 1'b0; man_ack = 1'b0; tick();
      enable = 1'b1;
      w = 0;
      while (!m.meas_valid && w < 60) begin
         tick();
         w++;
      end
      check("t4_first_valid", m.meas_valid, 1);
      hi = 5; lo = 5;
      repeat (45) tick();
      check("t4_valid_held", m.meas_valid, 1);
      check("t4_overrun", m.overrun, 1);
      check("t4_period_kept", m.period, 11);
      check("t4_div_kept", m.div_est, 4);
      gen_on = 1'b0; man_sig = 1'b0;
      repeat (5) tick();
      man_ack = 1'b1; tick();
      man_ack = 1'b0;
      check("t4_ack_clears", m.meas_valid, 0);
      check("t4_overrun_sticky", m.overrun, 1);
      repeat (3) tick();
      enable = 1'b0; tick();
      check("t4_dis_overrun", m.overrun, 0);
      check("t4_dis_period_held", m.period, 11);
      // timeout after a single rise, then re-measure from ARM
      enable = 1'b1;
      repeat (4) tick();
      man_sig = 1'b1;
      repeat (3) tick();
      man_sig = 1'b0;
      repeat (99) tick();
      check("t5_timeout_early", m.timeout, 0);
      tick();
      check("t5_timeout_set", m.timeout, 1);
      man_sig = 1'b1; repeat (10) tick();
      man_sig = 1'b0; repeat (10) tick();
      check("t5_arm_no_result", m.meas_valid, 0);
      man_sig = 1'b1; repeat (10) tick();
      check("t5_valid", m.meas_valid, 1);
      check("t5_period", m.period, 20);
      check("t5_div", m.div_est, 9);
      check("t5_timeout_sticky", m.timeout, 1);
      // reset in the middle of a measurement
      enable = 1'b0; man_sig = 1'b0; repeat (3) tick();
      enable = 1'b1; repeat (3) tick();
      man_sig = 1'b1; repeat (10) tick();
      reset = 1'b1; man_sig = 1'b0; tick();
      check("t6_rst_period", m.period, 0);
      check("t6_rst_div", m.div_est, 0);
      check("t6_rst_valid", m.meas_valid, 0);
      check("t6_rst_timeout", m.timeout, 0);
      reset = 1'b0; repeat (3) tick();
      man_sig = 1'b1; repeat (6) tick();
      man_sig = 1'b0; repeat (6) tick();
      check("t6_first_rise_no_result", m.meas_valid, 0);
      man_sig = 1'b1; repeat (6) tick();
      check("t6_valid", m.meas_valid, 1);
      check("t6_period", m.period, 12);
      check("t6_div", m.div_est, 5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
